// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states,
// forwarding select encodings and counter widths.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int CNT_W   = 32;
    localparam int WAIT_W  = 8;
    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;

    // MEM wins over WB so the youngest producer is picked; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             mem_wb_en,
        input logic             mem_is_load,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_wb_en,
        input logic [REG_W-1:0] wb_rd
    );
        if (src == '0)
            return FWD_RF;
        if (mem_wb_en && !mem_is_load && (mem_rd == src))
            return FWD_MEM;
        if (wb_wb_en && (wb_rd == src))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the pipeline sequencer (slave).
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1_index;
    logic [REG_W-1:0] id_rs2_index;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] ex_rs1_index;
    logic [REG_W-1:0] ex_rs2_index;
    logic [REG_W-1:0] ex_rd_index;
    logic             ex_wb_en;
    logic             ex_is_load;
    logic [REG_W-1:0] mem_rd_index;
    logic             mem_wb_en;
    logic             mem_is_load;
    logic [3:0]       mem_dm_w_en;
    logic             mem_branch_taken;
    logic             mem_halt;
    logic [REG_W-1:0] wb_rd_index;
    logic             wb_wb_en;
    logic             dm_ready;

    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             pc_sel_jb;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic             dm_req;
    logic             cpu_halted;
    logic             dm_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1_index, id_rs2_index, id_rs1_used, id_rs2_used,
               ex_rs1_index, ex_rs2_index, ex_rd_index, ex_wb_en, ex_is_load,
               mem_rd_index, mem_wb_en, mem_is_load, mem_dm_w_en,
               mem_branch_taken, mem_halt, wb_rd_index, wb_wb_en, dm_ready,
        input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               pc_sel_jb, fwd_rs1_sel, fwd_rs2_sel, dm_req, cpu_halted, dm_err,
               stall_cnt
    );

    modport slave (
        input  id_rs1_index, id_rs2_index, id_rs1_used, id_rs2_used,
               ex_rs1_index, ex_rs2_index, ex_rd_index, ex_wb_en, ex_is_load,
               mem_rd_index, mem_wb_en, mem_is_load, mem_dm_w_en,
               mem_branch_taken, mem_halt, wb_rd_index, wb_wb_en, dm_ready,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               pc_sel_jb, fwd_rs1_sel, fwd_rs2_sel, dm_req, cpu_halted, dm_err,
               stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational load-use detection (ID vs. EX load) and EX operand
// forwarding selects, one slice per source operand.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_S = NUM_SRC,
    parameter int RW    = REG_W
) (
    input  logic [NUM_S-1:0][RW-1:0] i_id_src_idx,
    input  logic [NUM_S-1:0]         i_id_src_used,
    input  logic [NUM_S-1:0][RW-1:0] i_ex_src_idx,
    input  logic [RW-1:0]            i_ex_rd_idx,
    input  logic                     i_ex_wb_en,
    input  logic                     i_ex_is_load,
    input  logic [RW-1:0]            i_mem_rd_idx,
    input  logic                     i_mem_wb_en,
    input  logic                     i_mem_is_load,
    input  logic [RW-1:0]            i_wb_rd_idx,
    input  logic                     i_wb_wb_en,
    output logic                     o_load_use,
    output logic [NUM_S-1:0][1:0]    o_fwd_sel
);

    logic             w_ex_load_wr;
    logic [NUM_S-1:0] w_lu_hit;

    // A load whose result lands in x0 can never be consumed, so it never stalls.
    assign w_ex_load_wr = i_ex_is_load && i_ex_wb_en && (i_ex_rd_idx != '0);

    for (genvar g = 0; g < NUM_S; g++) begin : g_src
        assign w_lu_hit[g]  = w_ex_load_wr && i_id_src_used[g] &&
                              (i_id_src_idx[g] == i_ex_rd_idx);
        assign o_fwd_sel[g] = fwd_sel(i_ex_src_idx[g], i_mem_wb_en, i_mem_is_load,
                                      i_mem_rd_idx, i_wb_wb_en, i_wb_rd_idx);
    end

    assign o_load_use = |w_lu_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, data-memory handshake,
// halt draining and stall accounting for the 5-stage core.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave io_pipe
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_e                 r_state;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic                   r_dm_err;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic                   w_mem_acc;
    logic                   w_mem_stall;
    logic                   w_load_use;
    logic [NUM_SRC-1:0][1:0] w_fwd;
    logic                   w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en;
    logic                   w_fd_flush, w_de_flush, w_em_flush;
    logic                   w_pc_sel_jb;
    logic                   w_dm_req;

    hazard_fwd_unit #(.NUM_S(NUM_SRC), .RW(REG_W)) u_hfu (
        .i_id_src_idx  ({io_pipe.id_rs2_index, io_pipe.id_rs1_index}),
        .i_id_src_used ({io_pipe.id_rs2_used,  io_pipe.id_rs1_used}),
        .i_ex_src_idx  ({io_pipe.ex_rs2_index, io_pipe.ex_rs1_index}),
        .i_ex_rd_idx   (io_pipe.ex_rd_index),
        .i_ex_wb_en    (io_pipe.ex_wb_en),
        .i_ex_is_load  (io_pipe.ex_is_load),
        .i_mem_rd_idx  (io_pipe.mem_rd_index),
        .i_mem_wb_en   (io_pipe.mem_wb_en),
        .i_mem_is_load (io_pipe.mem_is_load),
        .i_wb_rd_idx   (io_pipe.wb_rd_index),
        .i_wb_wb_en    (io_pipe.wb_wb_en),
        .o_load_use    (w_load_use),
        .o_fwd_sel     (w_fwd)
    );

    assign w_mem_acc   = io_pipe.mem_is_load || (io_pipe.mem_dm_w_en != 4'd0);
    assign w_mem_stall = w_mem_acc && !io_pipe.dm_ready;

    always_comb begin
        w_pc_en     = 1'b0;
        w_fd_en     = 1'b0;
        w_de_en     = 1'b0;
        w_em_en     = 1'b0;
        w_mw_en     = 1'b0;
        w_fd_flush  = 1'b0;
        w_de_flush  = 1'b0;
        w_em_flush  = 1'b0;
        w_pc_sel_jb = 1'b0;
        w_dm_req    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_dm_req = w_mem_acc;
                if (w_mem_stall) begin
                    w_pc_en = 1'b0;
                end else if (io_pipe.mem_halt) begin
                    // Freeze fetch, squash the younger stages, let the halt retire.
                    {w_fd_en, w_de_en, w_em_en, w_mw_en}    = 4'b1111;
                    {w_fd_flush, w_de_flush, w_em_flush} = 3'b111;
                end else if (io_pipe.mem_branch_taken) begin
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
                    {w_fd_flush, w_de_flush, w_em_flush}       = 3'b111;
                    w_pc_sel_jb = 1'b1;
                end else if (w_load_use) begin
                    // Hold PC and F/D, bubble into EX, older stages keep moving.
                    {w_de_en, w_em_en, w_mw_en} = 3'b111;
                    w_de_flush = 1'b1;
                end else begin
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
                end
            end
            ST_MEM_WAIT: begin
                w_dm_req = w_mem_acc;
                if (io_pipe.dm_ready)
                    {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b11111;
            end
            ST_DRAIN:   w_mw_en = 1'b1;
            ST_HALTED:  w_mw_en = 1'b0;
            default:    w_mw_en = 1'b0;
        endcase
        if (!rst) begin
            {w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en} = 5'b00000;
            {w_fd_flush, w_de_flush, w_em_flush}       = 3'b111;
            w_pc_sel_jb = 1'b0;
            w_dm_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_dm_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == ST_RUN || r_state == ST_MEM_WAIT) && !w_pc_en &&
                (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end else if (io_pipe.mem_halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (io_pipe.dm_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt >= MAX_WAIT_C) begin
                        r_dm_err <= 1'b1;
                        r_state  <= ST_HALTED;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_DRAIN:  r_state <= ST_HALTED;
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign io_pipe.pc_en       = w_pc_en;
    assign io_pipe.fd_en       = w_fd_en;
    assign io_pipe.de_en       = w_de_en;
    assign io_pipe.em_en       = w_em_en;
    assign io_pipe.mw_en       = w_mw_en;
    assign io_pipe.fd_flush    = w_fd_flush;
    assign io_pipe.de_flush    = w_de_flush;
    assign io_pipe.em_flush    = w_em_flush;
    assign io_pipe.pc_sel_jb   = w_pc_sel_jb;
    assign io_pipe.fwd_rs1_sel = rst ? w_fwd[0] : FWD_RF;
    assign io_pipe.fwd_rs2_sel = rst ? w_fwd[1] : FWD_RF;
    assign io_pipe.dm_req      = w_dm_req;
    assign io_pipe.cpu_halted  = rst && (r_state == ST_HALTED);
    assign io_pipe.dm_err      = r_dm_err;
    assign io_pipe.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor
// pops and compares against the sequencer outputs.
module tb_pipe_hazard_ctrl;

    localparam int MAXW = 4;

    typedef struct packed {
        logic [4:0] id_rs1, id_rs2;
        logic       id_u1, id_u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_wb, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_wb, mem_ld;
        logic [3:0] mem_we;
        logic       br, hlt;
        logic [4:0] wb_rd;
        logic       wb_wb, rdy;
    } in_t;

    typedef struct packed {
        logic [4:0]  en;   // pc, fd, de, em, mw
        logic [2:0]  fl;   // fd, de, em
        logic        sel;
        logic [1:0]  f1, f2;
        logic        req, hlt, err;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();
    pipe_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (.clk(clk), .rst(rst), .io_pipe(hz));

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: abstract pipeline condition flags and counters.
    int          m_wait   = 0;  // 0 = not waiting, else wait cycles seen
    bit          m_drain  = 0;
    bit          m_halted = 0;
    bit          m_err    = 0;
    logic [31:0] m_stall  = '0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] s, input in_t x);
        if (s == 0) return 2'b00;
        if (x.mem_wb && !x.mem_ld && x.mem_rd == s) return 2'b01;
        if (x.wb_wb && x.wb_rd == s) return 2'b10;
        return 2'b00;
    endfunction

    task automatic bump();
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    endtask

    task automatic model(input in_t x, input bit r, output exp_t e);
        bit acc, lu;
        e = '0;
        if (!r) begin
            e.fl = 3'b111;
            m_wait = 0; m_drain = 0; m_halted = 0; m_err = 0; m_stall = '0;
            return;
        end
        acc = x.mem_ld || (x.mem_we != 0);
        lu  = x.ex_ld && x.ex_wb && x.ex_rd != 0 &&
              ((x.id_u1 && x.id_rs1 == x.ex_rd) || (x.id_u2 && x.id_rs2 == x.ex_rd));
        e.f1 = ref_fwd(x.ex_rs1, x);
        e.f2 = ref_fwd(x.ex_rs2, x);
        e.hlt = m_halted; e.err = m_err; e.sc = m_stall;
        if (m_halted) begin
        end else if (m_drain) begin
            e.en = 5'b00001; m_drain = 0; m_halted = 1;
        end else if (m_wait != 0) begin
            e.req = acc;
            if (x.rdy) begin
                e.en = 5'b11111; m_wait = 0;
            end else begin
                bump();
                if (m_wait == MAXW) begin m_err = 1; m_halted = 1; m_wait = 0; end
                else m_wait++;
            end
        end else begin
            e.req = acc;
            if (acc && !x.rdy) begin
                bump(); m_wait = 1;
            end else if (x.hlt) begin
                e.en = 5'b01111; e.fl = 3'b111; bump(); m_drain = 1;
            end else if (x.br) begin
                e.en = 5'b11111; e.fl = 3'b111; e.sel = 1;
            end else if (lu) begin
                e.en = 5'b00111; e.fl = 3'b010; bump();
            end else begin
                e.en = 5'b11111;
            end
        end
    endtask

    task automatic step(input in_t x, input bit r);
        exp_t e;
        rst = r;
        hz.id_rs1_index = x.id_rs1;   hz.id_rs2_index = x.id_rs2;
        hz.id_rs1_used  = x.id_u1;    hz.id_rs2_used  = x.id_u2;
        hz.ex_rs1_index = x.ex_rs1;   hz.ex_rs2_index = x.ex_rs2;
        hz.ex_rd_index  = x.ex_rd;    hz.ex_wb_en     = x.ex_wb;
        hz.ex_is_load   = x.ex_ld;    hz.mem_rd_index = x.mem_rd;
        hz.mem_wb_en    = x.mem_wb;   hz.mem_is_load  = x.mem_ld;
        hz.mem_dm_w_en  = x.mem_we;   hz.mem_branch_taken = x.br;
        hz.mem_halt     = x.hlt;      hz.wb_rd_index  = x.wb_rd;
        hz.wb_wb_en     = x.wb_wb;    hz.dm_ready     = x.rdy;
        model(x, r, e);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic in_t idle();
        in_t x = '0;
        x.rdy = 1'b1;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.id_rs1 = 5'($urandom_range(0, 3)); x.id_rs2 = 5'($urandom_range(0, 3));
        x.id_u1  = 1'($urandom);             x.id_u2  = 1'($urandom);
        x.ex_rs1 = 5'($urandom_range(0, 3)); x.ex_rs2 = 5'($urandom_range(0, 3));
        x.ex_rd  = 5'($urandom_range(0, 3)); x.ex_wb  = 1'($urandom);
        x.ex_ld  = ($urandom_range(0, 2) == 0);
        x.mem_rd = 5'($urandom_range(0, 3)); x.mem_wb = 1'($urandom);
        x.mem_ld = ($urandom_range(0, 3) == 0);
        x.mem_we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        x.br     = ($urandom_range(0, 7) == 0);
        x.hlt    = ($urandom_range(0, 39) == 0);
        x.wb_rd  = 5'($urandom_range(0, 3)); x.wb_wb  = 1'($urandom);
        x.rdy    = ($urandom_range(0, 3) != 0);
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("enables", 32'({hz.pc_en, hz.fd_en, hz.de_en, hz.em_en, hz.mw_en}), 32'(e.en));
            chk("flushes", 32'({hz.fd_flush, hz.de_flush, hz.em_flush}), 32'(e.fl));
            chk("pc_sel_jb", 32'(hz.pc_sel_jb), 32'(e.sel));
            chk("fwd_rs1", 32'(hz.fwd_rs1_sel), 32'(e.f1));
            chk("fwd_rs2", 32'(hz.fwd_rs2_sel), 32'(e.f2));
            chk("dm_req", 32'(hz.dm_req), 32'(e.req));
            chk("cpu_halted", 32'(hz.cpu_halted), 32'(e.hlt));
            chk("dm_err", 32'(hz.dm_err), 32'(e.err));
            chk("stall_cnt", hz.stall_cnt, e.sc);
        end
    end

    initial begin
        in_t x;
        @(posedge clk); #1;
        step(rnd(), 1'b0);
        step(rnd(), 1'b0);
        // load-use: EX lw x5, ID add x6,x5,x1; then consumer sees x5 from WB
        x = idle(); x.ex_ld = 1; x.ex_wb = 1; x.ex_rd = 5;
        x.id_rs1 = 5; x.id_u1 = 1; x.id_rs2 = 1; x.id_u2 = 1;
        step(x, 1'b1);
        x = idle(); x.ex_rs1 = 5; x.ex_rs2 = 1; x.wb_rd = 5; x.wb_wb = 1;
        step(x, 1'b1);
        // MEM and WB both write x3; then same hazard on x0
        x = idle(); x.mem_rd = 3; x.mem_wb = 1; x.wb_rd = 3; x.wb_wb = 1; x.ex_rs1 = 3;
        step(x, 1'b1);
        x.mem_rd = 0; x.wb_rd = 0; x.ex_rs1 = 0;
        step(x, 1'b1);
        // store with 3 wait cycles
        x = idle(); x.mem_we = 4'hF; x.rdy = 0;
        repeat (3) step(x, 1'b1);
        x.rdy = 1;
        step(x, 1'b1);
        step(idle(), 1'b1);
        // branch together with load-use
        x = idle(); x.br = 1; x.ex_ld = 1; x.ex_wb = 1; x.ex_rd = 7; x.id_rs2 = 7; x.id_u2 = 1;
        step(x, 1'b1);
        // halt, drain, halted, then reset pulse
        x = idle(); x.hlt = 1;
        step(x, 1'b1);
        repeat (3) step(idle(), 1'b1);
        step(rnd(), 1'b0);
        step(idle(), 1'b1);
        // memory timeout
        x = idle(); x.mem_ld = 1; x.rdy = 0;
        repeat (7) step(x, 1'b1);
        step(rnd(), 1'b0);
        // random traffic with reset recovery once halted
        for (int i = 0; i < 800; i++) begin
            if (m_halted && $urandom_range(0, 2) == 0) step(rnd(), 1'b0);
            else step(rnd(), 1'b1);
        end
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage RISC-V core. Drives the enable and flush inputs of the F/D, D/E, E/M and M/W stage registers and produces EX-stage operand-forwarding selects. Runs the data-memory request handshake, load-use stalls, branch redirect flushes and halt draining. Sits beside the datapath; every stage register takes its `*_en` and `*_flush` from this block.

## Interface
- `MAX_WAIT`, 255: data-memory wait cycles before timeout; 1..255.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `id_rs1_index`, `id_rs2_index` in 5: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1: ID instruction actually reads rs1/rs2.
- `ex_rs1_index`, `ex_rs2_index` in 5: source registers in EX.
- `ex_rd_index` in 5; `ex_wb_en` in 1; `ex_is_load` in 1: EX destination, write enable, load flag (wb_sel=1).
- `mem_rd_index` in 5; `mem_wb_en` in 1; `mem_is_load` in 1: E/M register outputs.
- `mem_dm_w_en` in 4: E/M store byte enables.
- `mem_branch_taken` in 1; `mem_halt` in 1: E/M register outputs.
- `wb_rd_index` in 5; `wb_wb_en` in 1: M/W register outputs.
- `dm_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `fd_en`, `de_en`, `em_en`, `mw_en` out 1: stage-register load enables.
- `fd_flush`, `de_flush`, `em_flush` out 1: bubble insertion, meaning that register's control fields are cleared.
- `pc_sel_jb` out 1: PC loads the E/M `jb_addr`.
- `fwd_rs1_sel`, `fwd_rs2_sel` out 2: 00 register file, 01 MEM ALU result, 10 WB data.
- `dm_req` out 1: data-memory access request.
- `cpu_halted`, `dm_err` out 1: status.
- `stall_cnt` out 32: saturating count of stalled cycles.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Memory access definition: `mem_acc = mem_is_load | (mem_dm_w_en != 0)`. `dm_req = mem_acc` in RUN and MEM_WAIT, and 0 otherwise.
- Priority in RUN, highest first:
  1. Memory stall.
  2. Halt.
  3. Branch.
  4. Load-use.
- Memory stall: `mem_acc & !dm_req_ok`, where `dm_req_ok = dm_ready`.
  - All `*_en`=0 and no flushes.
  - RUN goes to MEM_WAIT; the wait counter loads 1.
- MEM_WAIT:
  - All enables stay 0.
  - On `dm_ready`, all enables are 1 that cycle and the state returns to RUN.
  - When the wait counter reaches `MAX_WAIT` without `dm_ready`: `dm_err`=1 (sticky) and the state goes to HALTED.
- Halt (`mem_halt` in RUN with no memory stall):
  - `pc_en`=0.
  - `fd_flush`, `de_flush` and `em_flush` are 1; `mw_en`=1.
  - State goes to DRAIN.
- DRAIN: lasts 1 cycle with `mw_en`=1 and all other enables 0, so the halt instruction retires. Then the state goes to HALTED.
- HALTED:
  - All enables 0 and `cpu_halted`=1.
  - Only `rst` exits this state.
- Branch (`mem_branch_taken`):
  - `pc_sel_jb`=1, `pc_en`=1.
  - `fd_flush`, `de_flush` and `em_flush` are 1, squashing 3 wrong-path instructions.
  - Any load-use condition in the same cycle is ignored.
- Load-use: `ex_is_load & ex_wb_en & ex_rd_index != 0`, matched against a used `id_rs1_index`/`id_rs2_index`.
  - `pc_en`=0, `fd_en`=0, `de_flush`=1.
  - E/M and M/W advance.
  - Exactly 1 bubble is inserted per occurrence.
- Forwarding, evaluated per source:
  - Select 01 if `mem_wb_en & !mem_is_load & mem_rd_index == src & src != 0`.
  - Otherwise select 10 if `wb_wb_en & wb_rd_index == src & src != 0`.
  - Otherwise select 00.
  - x0 is never forwarded.
- `stall_cnt` increments on every cycle in RUN or MEM_WAIT with `pc_en`=0, and saturates at 0xFFFF_FFFF.

## Timing
- Hazard outputs, forwarding selects and `dm_req` are combinational from the inputs and the current state. The state, wait counter, `dm_err` and `stall_cnt` are registered.
- While `rst`=0 (asynchronous), the outputs are:
  - state RUN; all `*_en`=0.
  - All flushes 1; `pc_sel_jb`=0.
  - `fwd_*`=00; `dm_req`=0.
  - `cpu_halted`=0, `dm_err`=0, `stall_cnt`=0.
- After `rst` deasserts, normal RUN behaviour applies from the first clock edge.
- Zero-wait memory (`dm_ready` in the same cycle as `dm_req`) costs no stall.
- Each wait cycle costs exactly 1 stall cycle.
- Branch or halt during MEM_WAIT is acted on only in the RUN cycle after `dm_ready`.
- Reset asserted mid-MEM_WAIT or DRAIN: the state goes to RUN immediately and the counters clear.

## Structure
- `pipe_ctrl_pkg`:
  - State enum.
  - `FWD_RF`/`FWD_MEM`/`FWD_WB` constants.
  - Counter width.
- One sub-module, `hazard_fwd_unit`: purely combinational load-use detection and forwarding selects. The FSM and counters stay in the top.

## Test plan
- EX `lw x5`, ID `add x6,x5,x1` → exactly 1 cycle of `pc_en`=0 and `de_flush`=1. On the next cycle `fwd_rs1_sel`=10.
- MEM `add x3` and WB `add x3` both writing, EX reads x3 → `fwd_rs1_sel`=01. The same hazard on x0 → 00.
- MEM store, `dm_ready` low for 3 cycles → 3 cycles of all enables 0 and `stall_cnt`=3. Then everything advances.
- `MAX_WAIT`=4, `dm_ready` never asserted → `dm_err`=1 and `cpu_halted`=1 after 4 cycles.
- `mem_branch_taken` together with a load-use in ID/EX → `pc_sel_jb`=1, 3 flushes, no stall.
- `mem_halt` → 1 DRAIN cycle with `mw_en`=1, then `cpu_halted`=1. Pulsing `rst` low returns to RUN with outputs at their reset values.
